// File: rtl/mac_arbiter_if.sv
// Bundle of the requester, datapath and response signals around the shared
// multiply-add arbiter. The arbiter uses the slave view; the environment
// driving requests and returning datapath results uses the master view.
interface mac_arbiter_if #(
    parameter int NREQ = 4
);
    logic                 hold;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [36*NREQ-1:0]   req_a;
    logic [36*NREQ-1:0]   req_b;
    logic [72*NREQ-1:0]   req_c;
    logic [35:0]          mac_a;
    logic [35:0]          mac_b;
    logic [71:0]          mac_c;
    logic [72:0]          mac_result;
    logic                 rsp_valid;
    logic [2:0]           rsp_id;
    logic [72:0]          rsp_data;
    logic                 busy;

    modport master (
        output hold, req_valid, req_a, req_b, req_c, mac_result,
        input  req_ready, mac_a, mac_b, mac_c, rsp_valid, rsp_id, rsp_data, busy
    );

    modport slave (
        input  hold, req_valid, req_a, req_b, req_c, mac_result,
        output req_ready, mac_a, mac_b, mac_c, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/mac_arbiter.sv
// Round-robin arbiter sharing one external 36x36+72 multiply-add datapath
// among NREQ requesters. One operation issues per cycle; a tag pipeline
// matching the datapath latency routes each result back to its owner.
module mac_arbiter #(
    parameter int NREQ    = 4,
    parameter int LATENCY = 3
) (
    input logic          clk,
    input logic          reset,
    mac_arbiter_if.slave bus
);
    localparam int PW = $clog2(NREQ);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          gnt_vld;
    logic [PW-1:0] gnt_idx;
    logic [2:0]    gnt_id;
    logic          tag_vld;
    logic [2:0]    tag_id;
    logic          tag_busy;

    // Search from the pointer with wrap; the lowest offset that is valid wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx     = '0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr_q) + k) % NREQ);
            if (bus.req_valid[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
        if (reset || bus.hold) begin
            gnt_vld = 1'b0;
            gnt_idx = '0;
        end
    end

    assign gnt_id = 3'(gnt_idx);

    // Grant strobe and operand mux; everything is zero when nothing is granted.
    always_comb begin
        bus.req_ready = '0;
        bus.mac_a     = '0;
        bus.mac_b     = '0;
        bus.mac_c     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_vld && (int'(gnt_idx) == i)) begin
                bus.req_ready[i] = 1'b1;
                bus.mac_a        = bus.req_a[i*36 +: 36];
                bus.mac_b        = bus.req_b[i*36 +: 36];
                bus.mac_c        = bus.req_c[i*72 +: 72];
            end
        end
    end

    // Pointer moves just past the winner; idle cycles leave it alone.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_vld) begin
            ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Pointer register; reset restores requester 0 as highest priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    if (LATENCY > 0) begin : g_tag
        logic [LATENCY:1]      vld_q;
        logic [LATENCY:1]      vld_d;
        logic [LATENCY:1][2:0] id_q;
        logic [LATENCY:1][2:0] id_d;

        // Shift the {valid,id} tags one stage per cycle; no back-pressure exists.
        always_comb begin
            vld_d    = '0;
            id_d     = '0;
            vld_d[1] = gnt_vld;
            id_d[1]  = gnt_vld ? gnt_id : 3'd0;
            for (int s = 2; s <= LATENCY; s++) begin
                vld_d[s] = vld_q[s-1];
                id_d[s]  = id_q[s-1];
            end
        end

        // Tag registers; reset drops every operation still in flight.
        always_ff @(posedge clk) begin
            if (reset) begin
                vld_q <= '0;
                id_q  <= '0;
            end else begin
                vld_q <= vld_d;
                id_q  <= id_d;
            end
        end

        assign tag_vld  = vld_q[LATENCY];
        assign tag_id   = id_q[LATENCY];
        assign tag_busy = |vld_q;
    end else begin : g_notag
        assign tag_vld  = gnt_vld;
        assign tag_id   = gnt_vld ? gnt_id : 3'd0;
        assign tag_busy = 1'b0;
    end

    assign bus.rsp_valid = tag_vld & ~reset;
    assign bus.rsp_id    = reset ? 3'd0 : tag_id;
    assign bus.rsp_data  = bus.rsp_valid ? bus.mac_result : '0;
    assign bus.busy      = tag_busy & ~reset;
endmodule

// File: tb/tb_mac_arbiter.sv
// Bench for mac_arbiter: a latency-matched multiply-add model stands in for
// the datapath, directed vectors drive requests, and a scoreboard queue holds
// the hand-computed responses that a negedge monitor checks.
module tb_mac_arbiter;
    localparam int NREQ    = 4;
    localparam int LATENCY = 3;

    typedef struct {
        int         cyc;
        logic [2:0] id;
        logic [72:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];

    mac_arbiter_if #(.NREQ(NREQ)) bus();

    mac_arbiter #(.NREQ(NREQ), .LATENCY(LATENCY)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External datapath model: A*B+C, delivered LATENCY cycles after issue.
    logic signed [72:0] sa, sb, sc, dp_in;
    logic [72:0] dp_q [0:LATENCY-1];

    always_comb begin
        sa    = 73'($signed(bus.mac_a));
        sb    = 73'($signed(bus.mac_b));
        sc    = 73'($signed(bus.mac_c));
        dp_in = sa * sb + sc;
    end

    always @(posedge clk) begin
        dp_q[0] <= dp_in;
        for (int s = 1; s < LATENCY; s++) dp_q[s] <= dp_q[s-1];
    end

    assign bus.mac_result = dp_q[LATENCY-1];

    task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [35:0] a, input logic [35:0] b,
                          input logic [71:0] c);
        bus.req_a[i*36 +: 36] = a;
        bus.req_b[i*36 +: 36] = b;
        bus.req_c[i*72 +: 72] = c;
    endtask

    // One cycle: check the grant vector, optionally queue the expected response.
    task automatic step(input logic [NREQ-1:0] exp_rdy, input int exp_id,
                        input logic [72:0] exp_data, input bit push);
        exp_t e;
        @(negedge clk);
        chk("req_ready", 73'(bus.req_ready), 73'(exp_rdy));
        if (push) begin
            e.cyc  = cyc + LATENCY;
            e.id   = 3'(exp_id);
            e.data = exp_data;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) step('0, 0, '0, 1'b0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic load_ladder();
        for (int i = 0; i < NREQ; i++) set_op(i, 36'(i + 1), 36'd10, 72'(i));
    endtask

    // Response monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (bus.rsp_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp at cycle %0d: got id %0d data %h, expected none",
                         cyc, bus.rsp_id, bus.rsp_data);
            end else begin
                e = sbq.pop_front();
                chk("rsp_cycle", 73'(cyc), 73'(e.cyc));
                chk("rsp_id", 73'(bus.rsp_id), 73'(e.id));
                chk("rsp_data", bus.rsp_data, e.data);
            end
        end else begin
            chk("rsp_idle_data", bus.rsp_data, '0);
        end
    end

    initial begin
        bus.hold      = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_c     = '0;

        // Reset state with every requester asking.
        load_ladder();
        bus.req_valid = '1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_ready", 73'(bus.req_ready), '0);
        chk("rst_rsp_valid", 73'(bus.rsp_valid), '0);
        chk("rst_rsp_id", 73'(bus.rsp_id), '0);
        chk("rst_busy", 73'(bus.busy), '0);
        chk("rst_mac_a", 73'(bus.mac_a), '0);
        chk("rst_mac_c", 73'(bus.mac_c), '0);
        @(posedge clk);
        #1;
        reset         = 1'b0;
        bus.req_valid = '0;

        // Single operation 2*3+4 from requester 0.
        set_op(0, 36'd2, 36'd3, 72'd4);
        bus.req_valid = 4'b0001;
        step(4'b0001, 0, 73'd10, 1'b1);
        bus.req_valid = '0;
        drain(5);

        // All requesters valid for 8 cycles: strict rotation from 0.
        pulse_reset();
        load_ladder();
        bus.req_valid = '1;
        for (int k = 0; k < 8; k++)
            step(4'(1 << (k % 4)), k % 4, 73'(10 * (k % 4 + 1) + k % 4), 1'b1);
        bus.req_valid = '0;
        drain(5);

        // Signed boundaries, back-to-back from the same requester.
        bus.req_valid = 4'b0001;
        set_op(0, 36'hF_FFFF_FFFF, 36'd1, 72'd0);
        step(4'b0001, 0, 73'h1_FFFF_FFFF_FFFF_FFFF_FF, 1'b1);
        set_op(0, 36'h8_0000_0000, 36'h8_0000_0000, 72'd0);
        step(4'b0001, 0, 73'h40_0000_0000_0000_0000, 1'b1);
        set_op(0, -36'd3, 36'd5, -72'd7);
        step(4'b0001, 0, -73'd22, 1'b1);
        bus.req_valid = '0;
        drain(5);

        // Pointer parked at 2 by a lone grant to 1, then 1 and 3 contend.
        set_op(1, 36'd7, 36'd6, 72'd1);
        set_op(3, -36'd4, 36'd9, 72'd100);
        bus.req_valid = 4'b0010;
        step(4'b0010, 1, 73'd43, 1'b1);
        bus.req_valid = 4'b1010;
        step(4'b1000, 3, 73'd64, 1'b1);
        step(4'b0010, 1, 73'd43, 1'b1);
        step(4'b1000, 3, 73'd64, 1'b1);
        bus.req_valid = '0;
        drain(5);

        // Three in flight, then hold: responses still arrive, busy drains.
        load_ladder();
        bus.req_valid = '1;
        step(4'b0001, 0, 73'd10, 1'b1);
        step(4'b0010, 1, 73'd21, 1'b1);
        step(4'b0100, 2, 73'd32, 1'b1);
        bus.hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("hold_ready", 73'(bus.req_ready), '0);
            chk("hold_busy", 73'(bus.busy), 73'(k < 3));
            @(posedge clk);
            #1;
        end

        // Two in flight then a one-cycle reset: both are discarded.
        bus.hold = 1'b0;
        step(4'b1000, 3, '0, 1'b0);
        step(4'b0001, 0, '0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 73'(bus.req_ready), '0);
        chk("midrst_busy", 73'(bus.busy), '0);
        chk("midrst_mac_b", 73'(bus.mac_b), '0);
        @(posedge clk);
        #1;
        reset         = 1'b0;
        bus.req_valid = 4'b1100;
        step(4'b0100, 2, 73'd32, 1'b1);
        bus.req_valid = '0;
        drain(6);

        for (int k = 0; k < 20 && sbq.size() != 0; k++) @(posedge clk);
        chk("sb_drained", 73'(sbq.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
